// File: rtl/quad_nco_if.sv
// Control and sample bus of the quadrature NCO: tuning/phase controls in,
// quadrature samples and their strobe out.
interface quad_nco_if #(
    parameter int PBITS = 32,
    parameter int QBITS = 15
);
    logic                    en_i;
    logic                    phase_clr_i;
    logic                    ftw_load_i;
    logic [PBITS-1:0]        ftw_i;
    logic [PBITS-1:0]        poff_i;
    logic signed [QBITS:0]   sin_o;
    logic signed [QBITS:0]   cos_o;
    logic                    valid_o;

    modport master (
        output en_i, phase_clr_i, ftw_load_i, ftw_i, poff_i,
        input  sin_o, cos_o, valid_o
    );

    modport slave (
        input  en_i, phase_clr_i, ftw_load_i, ftw_i, poff_i,
        output sin_o, cos_o, valid_o
    );
endinterface

// File: rtl/quad_nco.sv
// Quadrature NCO: phase accumulator plus offset, truncated and looked up in one
// shared quarter-wave sine table (two read ports). Two-stage pipeline.
module quad_nco #(
    parameter int PBITS = 32,
    parameter int ABITS = 8,
    parameter int QBITS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    quad_nco_if.slave  bus
);
    localparam int  QN = 2 ** (ABITS - 2);
    localparam real PI = 3.14159265358979323846;

    typedef logic [QN-1:0][QBITS-1:0] lut_t;

    function automatic lut_t gen_lut();
        lut_t t;
        for (int i = 0; i < QN; i++) begin
            t[i] = QBITS'($rtoi($sin(2.0 * PI * real'(i) / real'(2 ** ABITS))
                                * real'(2 ** QBITS)));
        end
        return t;
    endfunction

    localparam lut_t QLUT = gen_lut();

    function automatic logic [ABITS-1:0] phase_addr(input logic [PBITS-1:0] acc,
                                                     input logic [PBITS-1:0] poff);
        return ABITS'((acc + poff) >> (PBITS - ABITS));
    endfunction

    // Quadrant fold: odd quadrants read the table backwards (~l == QN-1-l), the
    // upper half negates. The stored magnitude is below 2**QBITS, so -s is safe.
    function automatic logic signed [QBITS:0] wave_lookup(input logic [ABITS-1:0] a);
        logic                  q;
        logic                  h;
        logic [ABITS-3:0]      l;
        logic [ABITS-3:0]      qa;
        logic signed [QBITS:0] s;
        q  = a[ABITS-1];
        h  = a[ABITS-2];
        l  = a[ABITS-3:0];
        qa = h ? ~l : l;
        s  = {1'b0, QLUT[qa]};
        return q ? -s : s;
    endfunction

    logic [PBITS-1:0]      acc_q, acc_d;
    logic [PBITS-1:0]      ftw_q, ftw_d;
    logic [ABITS-1:0]      as_p1_q, as_p1_d;
    logic [ABITS-1:0]      ac_p1_q, ac_p1_d;
    logic                  vld_p1_q, vld_p1_d;
    logic signed [QBITS:0] sin_p2_q, sin_p2_d;
    logic signed [QBITS:0] cos_p2_q, cos_p2_d;
    logic                  vld_p2_q, vld_p2_d;

    always_comb begin
        acc_d    = acc_q;
        ftw_d    = ftw_q;
        as_p1_d  = as_p1_q;
        ac_p1_d  = ac_p1_q;
        vld_p1_d = bus.en_i;
        sin_p2_d = sin_p2_q;
        cos_p2_d = cos_p2_q;
        vld_p2_d = vld_p1_q;

        // Stage 0: sample uses the accumulator value before this edge's update
        if (bus.phase_clr_i) begin
            acc_d = '0;
        end else if (bus.en_i) begin
            acc_d = acc_q + ftw_q;
        end
        if (bus.ftw_load_i) begin
            ftw_d = bus.ftw_i;
        end
        if (bus.en_i) begin
            as_p1_d = phase_addr(acc_q, bus.poff_i);
            ac_p1_d = as_p1_d + ABITS'(QN);
        end

        // Stage 1: table lookup, outputs hold between samples
        if (vld_p1_q) begin
            sin_p2_d = wave_lookup(as_p1_q);
            cos_p2_d = wave_lookup(ac_p1_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            ftw_q    <= '0;
            as_p1_q  <= '0;
            ac_p1_q  <= '0;
            vld_p1_q <= 1'b0;
            sin_p2_q <= '0;
            cos_p2_q <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            ftw_q    <= ftw_d;
            as_p1_q  <= as_p1_d;
            ac_p1_q  <= ac_p1_d;
            vld_p1_q <= vld_p1_d;
            sin_p2_q <= sin_p2_d;
            cos_p2_q <= cos_p2_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    assign bus.sin_o   = sin_p2_q;
    assign bus.cos_o   = cos_p2_q;
    assign bus.valid_o = vld_p2_q;

endmodule

// File: tb/tb_quad_nco.sv
// Scoreboard bench for quad_nco: driver predicts each sample from an ideal
// phase model, an independent monitor pops and compares on valid_o.
module tb_quad_nco;
    localparam int  PBITS = 32;
    localparam int  ABITS = 8;
    localparam int  QBITS = 15;
    localparam int  NFULL = 256;
    localparam int  NQ    = 64;
    localparam real PI    = 3.14159265358979323846;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    quad_nco_if #(.PBITS(PBITS), .QBITS(QBITS)) bus ();

    quad_nco #(.PBITS(PBITS), .ABITS(ABITS), .QBITS(QBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int s;
        int c;
        int due;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_acc  = '0;
    logic [31:0] m_ftw  = '0;
    int          last_s = 0;
    int          last_c = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal full-wave value at table address n: quarter-wave magnitude with the
    // descending quarters indexed from the top and the lower half positive.
    function automatic int golden(input int n);
        int quad;
        int r;
        int idx;
        int mag;
        quad = (n % NFULL) / NQ;
        r    = (n % NFULL) % NQ;
        idx  = (quad == 1 || quad == 3) ? (NQ - 1 - r) : r;
        mag  = $rtoi($sin(2.0 * PI * real'(idx) / real'(NFULL)) * 32768.0);
        return (quad >= 2) ? -mag : mag;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit en, input bit clr, input bit ld,
                        input logic [31:0] ftw, input logic [31:0] poff);
        logic [31:0] p;
        int          a;
        @(posedge clk);
        #1;
        bus.en_i        = en;
        bus.phase_clr_i = clr;
        bus.ftw_load_i  = ld;
        bus.ftw_i       = ftw;
        bus.poff_i      = poff;
        if (en) begin
            p = m_acc + poff;
            a = int'(p / 32'h0100_0000);
            sb.push_back('{golden(a), golden(a + NQ), cyc + 2});
        end
        if (clr)     m_acc = '0;
        else if (en) m_acc = m_acc + m_ftw;
        if (ld)      m_ftw = ftw;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.en_i = 1'b0; bus.phase_clr_i = 1'b0; bus.ftw_load_i = 1'b0;
        sb.delete();
        m_acc = '0;
        m_ftw = '0;
        #1;
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_sin", int'(bus.sin_o), 0);
        chk("rst_cos", int'(bus.cos_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_s = 0;
                last_c = 0;
            end else if (bus.valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("sin", int'(bus.sin_o), e.s);
                    chk("cos", int'(bus.cos_o), e.c);
                end
                last_s = int'(bus.sin_o);
                last_c = int'(bus.cos_o);
            end else begin
                chk("hold_sin", int'(bus.sin_o), last_s);
                chk("hold_cos", int'(bus.cos_o), last_c);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    chk("missing_valid", 0, 1);
                end
            end
        end
    end

    initial begin
        bus.en_i = 1'b0; bus.phase_clr_i = 1'b0; bus.ftw_load_i = 1'b0;
        bus.ftw_i = '0; bus.poff_i = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("init_valid", int'(bus.valid_o), 0);
        chk("init_sin", int'(bus.sin_o), 0);
        chk("init_cos", int'(bus.cos_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Quarter-turn steps
        step(0, 0, 1, 32'h4000_0000, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Full sweep of the table plus wrap
        step(0, 1, 1, 32'h0100_0000, 0);
        for (int i = 0; i < 258; i++) step(1, 0, 0, 0, 0);

        // Gapped enables
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);

        // Tuning-word load coinciding with an enable
        step(1, 0, 1, 32'h4000_0000, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);

        // Half-turn offset, then clear mid-stream with enable
        step(0, 1, 1, 32'h0100_0000, 0);
        step(1, 0, 0, 0, 32'h8000_0000);
        step(1, 0, 0, 0, 32'h8000_0000);
        step(1, 1, 0, 0, 32'h8000_0000);
        step(1, 0, 0, 0, 32'h8000_0000);
        step(1, 1, 1, 32'h0300_0000, 32'h1234_5678);
        step(1, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 9) == 0), $urandom(), $urandom());
        end

        // Reset with samples in flight, then constant output with zero tuning word
        step(1, 0, 0, 0, 32'h2000_0000);
        step(1, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("drain_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
